// File: rtl/motion_pkg.sv
// motion_pkg: shared state encoding, mask byte values and default frame geometry for the motion-mask producer.
package motion_pkg;

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_WRITE = 2'd1
    } state_t;

    localparam logic [7:0] MASK_MOTION = 8'h00;
    localparam logic [7:0] MASK_STATIC = 8'hFF;

    localparam int DEF_WIDTH  = 720;
    localparam int DEF_HEIGHT = 540;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/rgb_to_gray.sv
// rgb_to_gray: combinational gray = ((R+G+B)*85)>>8, shared by the frame path and background capture.
module rgb_to_gray (
    input  logic [23:0] rgb,
    output logic [7:0]  gray
);

    logic [9:0]  sum;
    logic [16:0] prod;

    always_comb begin
        sum  = 10'(rgb[23:16]) + 10'(rgb[15:8]) + 10'(rgb[7:0]);
        prod = 17'(sum) * 17'd85;
        gray = 8'(prod >> 8);
    end

endmodule

// File: rtl/motion_mask_gen.sv
// motion_mask_gen: pops background gray + frame RGB, thresholds the gray difference, pushes mask and original pixel.
// Define MOTION_COUNT_EN to add the per-frame motion_count output.
module motion_mask_gen
    import motion_pkg::*;
#(
    parameter int         WIDTH     = DEF_WIDTH,
    parameter int         HEIGHT    = DEF_HEIGHT,
    parameter logic [7:0] THRESHOLD = 8'd50,
    localparam int        CW        = $clog2(WIDTH * HEIGHT)
`ifdef MOTION_COUNT_EN
    ,
    localparam int        MW        = $clog2(WIDTH * HEIGHT + 1)
`endif
) (
    input  logic          clock,
    input  logic          reset,
    output logic          base_rd_en,
    input  logic          base_empty,
    input  logic [7:0]    base_dout,
    output logic          frame_rd_en,
    input  logic          frame_empty,
    input  logic [23:0]   frame_dout,
    output logic          mask_wr_en,
    input  logic          mask_full,
    output logic [7:0]    mask_din,
    output logic          original_wr_en,
    input  logic          original_full,
    output logic [23:0]   original_din,
    output logic          frame_done
`ifdef MOTION_COUNT_EN
    ,
    output logic [MW-1:0] motion_count
`endif
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH * HEIGHT - 1);

    state_t        state_q, state_d;
    logic [7:0]    mask_q, mask_d;
    logic [23:0]   pix_q, pix_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    gray, mask_now;
    logic          pop, push;

    rgb_to_gray u_gray (
        .rgb  (frame_dout),
        .gray (gray)
    );

    // Reset gates both handshakes so nothing is popped or pushed in the reset cycle.
    always_comb begin
        pop      = 1'b0;
        push     = 1'b0;
        state_d  = S_READ;
        mask_now = (abs_diff(gray, base_dout) > THRESHOLD) ? MASK_MOTION : MASK_STATIC;
        case (state_q)
            S_READ: begin
                pop     = !reset && !base_empty && !frame_empty;
                state_d = pop ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                push    = !reset && !mask_full && !original_full;
                state_d = push ? S_READ : S_WRITE;
            end
            default: state_d = S_READ;
        endcase
        mask_d         = pop ? mask_now : mask_q;
        pix_d          = pop ? frame_dout : pix_q;
        frame_done     = push && (cnt_q == LAST);
        cnt_d          = push ? (frame_done ? '0 : cnt_q + CW'(1)) : cnt_q;
        base_rd_en     = pop;
        frame_rd_en    = pop;
        mask_wr_en     = push;
        original_wr_en = push;
        mask_din       = push ? mask_q : '0;
        original_din   = push ? pix_q : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_READ;
            mask_q  <= '0;
            pix_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pix_q   <= pix_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MOTION_COUNT_EN
    logic [MW-1:0] acc_q, acc_d, motion_count_q, motion_count_d;
    logic          hit;

    // The final total includes the pixel written on the frame_done cycle itself.
    always_comb begin
        hit            = push && (mask_q == MASK_MOTION);
        acc_d          = frame_done ? '0 : acc_q + MW'(hit);
        motion_count_d = frame_done ? acc_q + MW'(hit) : motion_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q          <= '0;
            motion_count_q <= '0;
        end else begin
            acc_q          <= acc_d;
            motion_count_q <= motion_count_d;
        end
    end

    assign motion_count = motion_count_q;
`endif

endmodule

// File: tb/tb_motion_mask_gen.sv
// tb_motion_mask_gen: directed scenarios plus a randomized stream checked against an arithmetic reference model.
module tb_motion_mask_gen;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        base_rd_en, base_empty, frame_rd_en, frame_empty;
    logic        mask_wr_en, mask_full, original_wr_en, original_full, frame_done;
    logic [7:0]  base_dout, mask_din;
    logic [23:0] frame_dout, original_din;
`ifdef MOTION_COUNT_EN
    logic [3:0]  motion_count;
`endif

    int vecs = 0;
    int errs = 0;

    // Reference model state: at most one popped-but-unwritten pixel.
    int          pend_n;
    logic [7:0]  pend_mask;
    logic [23:0] pend_pix;
    int          wcount, macc, mcount;

    always #5 clock = ~clock;

    motion_mask_gen #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock          (clock),
        .reset          (reset),
        .base_rd_en     (base_rd_en),
        .base_empty     (base_empty),
        .base_dout      (base_dout),
        .frame_rd_en    (frame_rd_en),
        .frame_empty    (frame_empty),
        .frame_dout     (frame_dout),
        .mask_wr_en     (mask_wr_en),
        .mask_full      (mask_full),
        .mask_din       (mask_din),
        .original_wr_en (original_wr_en),
        .original_full  (original_full),
        .original_din   (original_din),
        .frame_done     (frame_done)
`ifdef MOTION_COUNT_EN
        ,
        .motion_count   (motion_count)
`endif
    );

    function automatic logic [7:0] ref_mask(input int b, input logic [23:0] p);
        int r, g, bl, gray, d;
        r    = p[23:16];
        g    = p[15:8];
        bl   = p[7:0];
        gray = ((r + g + bl) * 85) / 256;
        d    = (gray > b) ? gray - b : b - gray;
        return (d > 50) ? 8'h00 : 8'hFF;
    endfunction

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic be, input logic fe, input logic [7:0] bd,
                          input logic [23:0] fd, input logic mf, input logic of);
        base_empty    = be;
        frame_empty   = fe;
        base_dout     = bd;
        frame_dout    = fd;
        mask_full     = mf;
        original_full = of;
    endtask

    task automatic do_reset();
        set_in(1, 1, 0, 0, 0, 0);
        reset = 1'b1;
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    task automatic pop_write(input logic [7:0] bd, input logic [23:0] fd, output logic ok,
                             output logic [7:0] m, output logic [23:0] o, output logic done);
        set_in(0, 0, bd, fd, 0, 0);
        #4;
        ok = base_rd_en && frame_rd_en;
        nxt();
        set_in(1, 1, 0, 0, 0, 0);
        #4;
        ok   = ok && mask_wr_en && original_wr_en && !base_rd_en && !frame_rd_en;
        m    = mask_din;
        o    = original_din;
        done = frame_done;
        nxt();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 0, 8'h12, 24'h345678, 0, 0);
        for (int c = 0; c < 2; c++) begin
            nxt();
            #4;
            vecs++;
            if ({base_rd_en, frame_rd_en, mask_wr_en, original_wr_en, frame_done} !== 5'b0) begin
                errs++;
                $display("FAIL reset_enables got %b want 00000",
                         {base_rd_en, frame_rd_en, mask_wr_en, original_wr_en, frame_done});
            end
            vecs++;
            if ({mask_din, original_din} !== 32'h0) begin
                errs++;
                $display("FAIL reset_data got %h want 0", {mask_din, original_din});
            end
`ifdef MOTION_COUNT_EN
            vecs++;
            if (motion_count !== 4'd0) begin
                errs++;
                $display("FAIL reset_motion_count got %0d want 0", motion_count);
            end
`endif
        end
        nxt();
        reset = 1'b0;
        set_in(1, 1, 0, 0, 0, 0);
        nxt();
    endtask

    task automatic test_pixel();
        set_in(0, 0, 8'h00, 24'h646464, 0, 0);
        #4;
        vecs++;
        if ({base_rd_en, frame_rd_en} !== 2'b11) begin
            errs++;
            $display("FAIL pixel_pop got %b want 11", {base_rd_en, frame_rd_en});
        end
        nxt();
        set_in(1, 1, 0, 0, 0, 0);
        #4;
        vecs++;
        if ({mask_wr_en, original_wr_en, base_rd_en, frame_rd_en} !== 4'b1100) begin
            errs++;
            $display("FAIL pixel_write_en got %b want 1100",
                     {mask_wr_en, original_wr_en, base_rd_en, frame_rd_en});
        end
        vecs++;
        if (mask_din !== 8'h00) begin
            errs++;
            $display("FAIL pixel_mask got %h want 00", mask_din);
        end
        vecs++;
        if (original_din !== 24'h646464) begin
            errs++;
            $display("FAIL pixel_original got %h want 646464", original_din);
        end
        nxt();
        #4;
        vecs++;
        if ({mask_wr_en, original_wr_en, mask_din, original_din} !== 34'h0) begin
            errs++;
            $display("FAIL pixel_idle_after_write got %h want 0",
                     {mask_wr_en, original_wr_en, mask_din, original_din});
        end
        nxt();
    endtask

    task automatic test_threshold();
        logic [7:0]  bd [4] = '{8'd0, 8'd0, 8'd100, 8'd101};
        logic [23:0] fd [4] = '{24'h323233, 24'h333334, 24'h323233, 24'h323233};
        logic [7:0]  ex [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        logic        ok, done;
        logic [7:0]  m;
        logic [23:0] o;
        for (int i = 0; i < 4; i++) begin
            pop_write(bd[i], fd[i], ok, m, o, done);
            vecs++;
            if (!ok || m !== ex[i] || o !== fd[i]) begin
                errs++;
                $display("FAIL threshold_%0d got ok=%b mask=%h orig=%h want ok=1 mask=%h orig=%h",
                         i, ok, m, o, ex[i], fd[i]);
            end
        end
    endtask

    task automatic test_gating();
        set_in(0, 1, 8'h55, 24'hABCDEF, 0, 0);
        for (int c = 0; c < 13; c++) begin
            if (c == 10) set_in(1, 0, 8'h55, 24'hABCDEF, 0, 0);
            #4;
            vecs++;
            if ({base_rd_en, frame_rd_en} !== 2'b00) begin
                errs++;
                $display("FAIL gating_cycle_%0d got %b want 00", c, {base_rd_en, frame_rd_en});
            end
            nxt();
        end
        set_in(1, 1, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        set_in(0, 0, 8'd200, 24'h102030, 0, 0);
        #4;
        vecs++;
        if ({base_rd_en, frame_rd_en} !== 2'b11) begin
            errs++;
            $display("FAIL bp_pop got %b want 11", {base_rd_en, frame_rd_en});
        end
        nxt();
        set_in(0, 0, 8'h01, 24'hFFFFFE, 0, 1);
        for (int c = 0; c < 5; c++) begin
            #4;
            vecs++;
            if ({mask_wr_en, original_wr_en, base_rd_en, frame_rd_en} !== 4'b0000) begin
                errs++;
                $display("FAIL bp_stall_%0d got %b want 0000", c,
                         {mask_wr_en, original_wr_en, base_rd_en, frame_rd_en});
            end
            nxt();
        end
        set_in(1, 1, 0, 0, 0, 0);
        #4;
        vecs++;
        if ({mask_wr_en, original_wr_en, mask_din, original_din} !== {2'b11, 8'h00, 24'h102030}) begin
            errs++;
            $display("FAIL bp_release got %h want %h", {mask_wr_en, original_wr_en, mask_din, original_din},
                     {2'b11, 8'h00, 24'h102030});
        end
        nxt();
    endtask

    task automatic test_frame_wrap();
        logic        ok, done, motion;
        logic [7:0]  m;
        logic [23:0] o;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            motion = (k == 0 || k == 3 || k == 5 || k == 10);
            pop_write(motion ? 8'd0 : 8'd99, 24'h646464, ok, m, o, done);
            vecs++;
            if (!ok || m !== (motion ? 8'h00 : 8'hFF)) begin
                errs++;
                $display("FAIL wrap_pixel_%0d got ok=%b mask=%h want ok=1 mask=%h", k, ok, m,
                         motion ? 8'h00 : 8'hFF);
            end
            vecs++;
            if (done !== (k == 7 || k == 15)) begin
                errs++;
                $display("FAIL wrap_done_%0d got %b want %b", k, done, (k == 7 || k == 15));
            end
`ifdef MOTION_COUNT_EN
            if (k == 7 || k == 15) begin
                #4;
                vecs++;
                if (motion_count !== ((k == 7) ? 4'd3 : 4'd1)) begin
                    errs++;
                    $display("FAIL wrap_motion_count_%0d got %0d want %0d", k, motion_count,
                             (k == 7) ? 3 : 1);
                end
                nxt();
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        logic        ok, done;
        logic [7:0]  m;
        logic [23:0] o;
        do_reset();
        set_in(0, 0, 8'd0, 24'h646464, 0, 0);
        nxt();
        set_in(1, 1, 0, 0, 1, 0);
        #4;
        vecs++;
        if (mask_wr_en !== 1'b0) begin
            errs++;
            $display("FAIL midrst_full_stall got %b want 0", mask_wr_en);
        end
        nxt();
        reset = 1'b1;
        set_in(0, 0, 8'd0, 24'h646464, 1, 0);
        #4;
        vecs++;
        if ({base_rd_en, frame_rd_en, mask_wr_en, original_wr_en} !== 4'b0000) begin
            errs++;
            $display("FAIL midrst_reset_cycle got %b want 0000",
                     {base_rd_en, frame_rd_en, mask_wr_en, original_wr_en});
        end
        nxt();
        reset = 1'b0;
        set_in(1, 1, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #4;
            vecs++;
            if ({mask_wr_en, original_wr_en} !== 2'b00) begin
                errs++;
                $display("FAIL midrst_discard_%0d got %b want 00", c, {mask_wr_en, original_wr_en});
            end
            nxt();
        end
        for (int k = 0; k < N; k++) begin
            pop_write(8'd99, 24'h646464, ok, m, o, done);
            vecs++;
            if (!ok || m !== 8'hFF || done !== (k == N - 1)) begin
                errs++;
                $display("FAIL midrst_after_%0d got ok=%b mask=%h done=%b want ok=1 mask=ff done=%b",
                         k, ok, m, done, (k == N - 1));
            end
        end
    endtask

    task automatic test_random();
        logic        r_rst, be, fe, mf, of, e_rd, e_wr, e_done;
        logic [7:0]  bd, e_m;
        logic [23:0] fd, e_o;
        do_reset();
        pend_n = 0;
        wcount = 0;
        macc   = 0;
        mcount = 0;
        for (int c = 0; c < 600; c++) begin
            r_rst = ($urandom_range(63) == 0);
            be    = ($urandom_range(3) == 0);
            fe    = ($urandom_range(3) == 0);
            mf    = ($urandom_range(3) == 0);
            of    = ($urandom_range(3) == 0);
            bd    = 8'($urandom);
            fd    = 24'($urandom);
            reset = r_rst;
            set_in(be, fe, bd, fd, mf, of);
            #4;
            e_rd   = !r_rst && pend_n == 0 && !be && !fe;
            e_wr   = !r_rst && pend_n == 1 && !mf && !of;
            e_m    = e_wr ? pend_mask : 8'h00;
            e_o    = e_wr ? pend_pix : 24'h0;
            e_done = e_wr && wcount == N - 1;
            vecs++;
            if ({base_rd_en, frame_rd_en, mask_wr_en, original_wr_en} !== {e_rd, e_rd, e_wr, e_wr}) begin
                errs++;
                $display("FAIL rand_enables_%0d got %b want %b", c,
                         {base_rd_en, frame_rd_en, mask_wr_en, original_wr_en}, {e_rd, e_rd, e_wr, e_wr});
            end
            vecs++;
            if (mask_din !== e_m || original_din !== e_o) begin
                errs++;
                $display("FAIL rand_data_%0d got %h/%h want %h/%h", c, mask_din, original_din, e_m, e_o);
            end
            vecs++;
            if (frame_done !== e_done) begin
                errs++;
                $display("FAIL rand_done_%0d got %b want %b", c, frame_done, e_done);
            end
`ifdef MOTION_COUNT_EN
            vecs++;
            if (motion_count !== 4'(mcount)) begin
                errs++;
                $display("FAIL rand_motion_count_%0d got %0d want %0d", c, motion_count, mcount);
            end
`endif
            if (r_rst) begin
                pend_n = 0;
                wcount = 0;
                macc   = 0;
                mcount = 0;
            end else if (e_rd) begin
                pend_n    = 1;
                pend_mask = ref_mask(int'(bd), fd);
                pend_pix  = fd;
            end else if (e_wr) begin
                pend_n = 0;
                if (pend_mask == 8'h00) macc++;
                if (wcount == N - 1) begin
                    mcount = macc;
                    macc   = 0;
                    wcount = 0;
                end else begin
                    wcount++;
                end
            end
            nxt();
        end
        reset = 1'b0;
        set_in(1, 1, 0, 0, 0, 0);
    endtask

    initial begin
        set_in(1, 1, 0, 0, 0, 0);
        test_reset();
        test_pixel();
        test_threshold();
        test_gating();
        test_backpressure();
        test_frame_wrap();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
